switch_event_conditioner: RTL

//   Conditions the raw board slide switch before it reaches the HPS switch PIO input (switch_export).

---
 rtl/switch_event_conditioner_if.sv | 27 ++
 rtl/switch_event_conditioner.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/switch_event_conditioner_if.sv
// Event record and debounced level exchanged between the switch conditioner and the HPS PIO side.
interface switch_event_conditioner_if;
    logic       switch_export;
    logic       event_valid;
    logic       event_rise;
    logic       event_ack;
    logic [7:0] event_count;
    logic       overrun;

    modport master (
        output switch_export,
        output event_valid,
        output event_rise,
        input  event_ack,
        output event_count,
        output overrun
    );

    modport slave (
        input  switch_export,
        input  event_valid,
        input  event_rise,
        output event_ack,
        input  event_count,
        input  overrun
    );
endinterface

// File: rtl/switch_event_conditioner.sv
// Synchronises and debounces the raw slide switch, and publishes each accepted
// transition as a valid/ack event record with a sticky overrun flag.
module switch_event_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          switch,
    switch_event_conditioner_if.master    evt
);

    typedef enum logic [1:0] {STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO} state_t;

    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_ff;
    logic                   sync;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             accept;
    logic             accept_level;

    logic       export_q, export_next;
    logic       valid_q, valid_next;
    logic       rise_q, rise_next;
    logic [7:0] count_q, count_next;
    logic       overrun_q, overrun_next;

    assign sync = sync_ff[SYNC_STAGES-1];

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_ff   <= '0;
            state     <= STABLE_LO;
            cnt       <= '0;
            export_q  <= 1'b0;
            valid_q   <= 1'b0;
            rise_q    <= 1'b0;
            count_q   <= 8'd0;
            overrun_q <= 1'b0;
        end else begin
            sync_ff   <= {sync_ff[SYNC_STAGES-2:0], switch};
            state     <= state_next;
            cnt       <= cnt_next;
            export_q  <= export_next;
            valid_q   <= valid_next;
            rise_q    <= rise_next;
            count_q   <= count_next;
            overrun_q <= overrun_next;
        end
    end

    // A level reverting during WAIT is a glitch and takes priority over acceptance.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        accept       = 1'b0;
        accept_level = 1'b0;
        case (state)
            STABLE_LO: begin
                if (sync) begin
                    state_next = WAIT_HI;
                    cnt_next   = CNT_ONE;
                end else begin
                    cnt_next = '0;
                end
            end
            WAIT_HI: begin
                if (!sync) begin
                    state_next = STABLE_LO;
                    cnt_next   = '0;
                end else if (cnt == CNT_LIMIT) begin
                    state_next   = STABLE_HI;
                    cnt_next     = '0;
                    accept       = 1'b1;
                    accept_level = 1'b1;
                end else begin
                    cnt_next = cnt + CNT_ONE;
                end
            end
            STABLE_HI: begin
                if (!sync) begin
                    state_next = WAIT_LO;
                    cnt_next   = CNT_ONE;
                end else begin
                    cnt_next = '0;
                end
            end
            WAIT_LO: begin
                if (sync) begin
                    state_next = STABLE_HI;
                    cnt_next   = '0;
                end else if (cnt == CNT_LIMIT) begin
                    state_next   = STABLE_LO;
                    cnt_next     = '0;
                    accept       = 1'b1;
                    accept_level = 1'b0;
                end else begin
                    cnt_next = cnt + CNT_ONE;
                end
            end
            default: begin
                state_next = STABLE_LO;
                cnt_next   = '0;
            end
        endcase
    end

    // An ack landing with a new acceptance consumes the old event, so no overrun.
    always_comb begin
        export_next  = export_q;
        valid_next   = valid_q;
        rise_next    = rise_q;
        count_next   = count_q;
        overrun_next = overrun_q;
        if (accept) begin
            export_next = accept_level;
            valid_next  = 1'b1;
            rise_next   = accept_level;
            count_next  = count_q + 8'd1;
            if (valid_q && evt.event_ack) begin
                overrun_next = 1'b0;
            end else if (valid_q) begin
                overrun_next = 1'b1;
            end
        end else if (valid_q && evt.event_ack) begin
            valid_next   = 1'b0;
            overrun_next = 1'b0;
        end
    end

    assign evt.switch_export = export_q;
    assign evt.event_valid   = valid_q;
    assign evt.event_rise    = rise_q;
    assign evt.event_count   = count_q;
    assign evt.overrun       = overrun_q;

endmodule
